// File: rtl/bp_pkg.sv
// Shared types and fixed-point helpers for the sequential back-propagation updater.
package bp_pkg;

  localparam int unsigned BP_W    = 32;
  localparam int unsigned BP_FRAC = 16;
  // Working width for saturation: wide enough for a full 2W-bit product up to W=64.
  localparam int unsigned SAT_W   = 130;

  localparam logic signed [BP_W-1:0] ONE  = BP_W'(1) << BP_FRAC;
  localparam logic signed [BP_W-1:0] MAXV = {1'b0, {(BP_W-1){1'b1}}};
  localparam logic signed [BP_W-1:0] MINV = {1'b1, {(BP_W-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StThresh,
    StDone
  } bp_state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                  input int unsigned w);
    logic signed [SAT_W-1:0] maxv;
    logic signed [SAT_W-1:0] minv;
    maxv = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    minv = ~maxv;
    if (x > maxv) begin
      sat = maxv;
    end else if (x < minv) begin
      sat = minv;
    end else begin
      sat = x;
    end
  endfunction

endpackage

// File: rtl/bp_seq_updater_if.sv
// Bundle-in / result-out handshake between the error stage, the updater and the weight store.
interface bp_seq_updater_if #(
  parameter int unsigned N_IN = 32,
  parameter int unsigned W    = 32
) ();

  logic                    bp_in_valid;
  logic                    bp_in_ready;
  logic [N_IN-1:0][W-1:0]  bp_ds;
  logic [N_IN:0][W-1:0]    bp_w;
  logic [W-1:0]            bp_err;
  logic [W-1:0]            bp_rate;
  logic [W-1:0]            bp_decay;
  logic                    bp_flush;
  logic                    bp_out_valid;
  logic                    bp_out_ready;
  logic [N_IN-1:0][W-1:0]  bp_bc;
  logic [N_IN:0][W-1:0]    bp_wn;
  logic                    bp_busy;
  logic [15:0]             bp_upd_cnt;

  modport master (
    output bp_in_valid, bp_ds, bp_w, bp_err, bp_rate, bp_decay, bp_flush, bp_out_ready,
    input  bp_in_ready, bp_out_valid, bp_bc, bp_wn, bp_busy, bp_upd_cnt
  );

  modport slave (
    input  bp_in_valid, bp_ds, bp_w, bp_err, bp_rate, bp_decay, bp_flush, bp_out_ready,
    output bp_in_ready, bp_out_valid, bp_bc, bp_wn, bp_busy, bp_upd_cnt
  );

endinterface

// File: rtl/bp_lane.sv
// Combinational single-weight update and blame computation; also handles the threshold weight.
module bp_lane
  import bp_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 16
) (
  input  logic signed [W-1:0] ds,
  input  logic signed [W-1:0] w,
  input  logic signed [W-1:0] err,
  input  logic signed [W-1:0] rate,
  input  logic signed [W-1:0] decay,
  input  logic                is_thresh,
  output logic signed [W-1:0] wn,
  output logic signed [W-1:0] bc
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned WS = W + 2;

  logic signed [W2-1:0] p_grad, p_step, p_dec, p_thr, p_bc;
  logic signed [W-1:0]  grad, step, dec, thr;
  logic signed [WS-1:0] sum;

  always_comb begin
    p_grad = W2'(err) * W2'(ds);
    grad   = W'(p_grad >>> FRAC);
    p_step = W2'(grad) * W2'(rate);
    step   = W'(p_step >>> FRAC);
    p_dec  = W2'(w) * W2'(decay);
    dec    = W'(p_dec >>> FRAC);
    p_thr  = W2'(err) * W2'(rate);
    thr    = W'(p_thr >>> FRAC);
    p_bc   = W2'(err) * W2'(w);

    // The threshold input is a constant -1 activation, hence the subtracted step.
    if (is_thresh) begin
      sum = WS'(w) - WS'(thr) - WS'(dec);
    end else begin
      sum = WS'(w) + WS'(step) - WS'(dec);
    end

    wn = W'(sat(SAT_W'(sum), W));
    bc = W'(sat(SAT_W'(p_bc >>> FRAC), W));
  end

endmodule

// File: rtl/bp_seq_updater.sv
// Sequential per-neuron weight updater: LANES weights per cycle, then the threshold weight.
module bp_seq_updater
  import bp_pkg::*;
#(
  parameter int unsigned N_IN  = 32,
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned FRAC  = 16
) (
  input logic             clk,
  input logic             rst_n,
  bp_seq_updater_if.slave bus
);

  localparam int unsigned NG = (N_IN + LANES - 1) / LANES;
  localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned DW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned WW = $clog2(N_IN + 1);

  bp_state_t              state_q;
  logic [GW-1:0]          grp_q;
  logic [N_IN-1:0][W-1:0] ds_q;
  logic [N_IN:0][W-1:0]   w_q;
  logic [W-1:0]           err_q, rate_q, decay_q;
  logic [N_IN-1:0][W-1:0] bc_q;
  logic [N_IN:0][W-1:0]   wn_q;
  logic                   out_valid_q;
  logic [15:0]            cnt_q;

  logic signed [W-1:0] l_ds [LANES];
  logic signed [W-1:0] l_w  [LANES];
  logic signed [W-1:0] l_wn [LANES];
  logic signed [W-1:0] l_bc [LANES];
  logic                l_thr[LANES];
  logic                l_en [LANES];
  int unsigned         l_idx[LANES];

  // Lane operand select; lanes past N_IN in the last group stay masked.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      l_idx[l] = int'(grp_q) * LANES + l;
      l_ds[l]  = '0;
      l_w[l]   = '0;
      l_thr[l] = 1'b0;
      l_en[l]  = 1'b0;
      if (l_idx[l] < N_IN) begin
        l_en[l] = (state_q == StRun);
        l_ds[l] = ds_q[DW'(l_idx[l])];
        l_w[l]  = w_q[WW'(l_idx[l])];
      end
    end
    if (state_q == StThresh) begin
      l_ds[0]  = '0;
      l_w[0]   = w_q[N_IN];
      l_thr[0] = 1'b1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bp_lane #(
      .W    (W),
      .FRAC (FRAC)
    ) u_lane (
      .ds        (l_ds[l]),
      .w         (l_w[l]),
      .err       (err_q),
      .rate      (rate_q),
      .decay     (decay_q),
      .is_thresh (l_thr[l]),
      .wn        (l_wn[l]),
      .bc        (l_bc[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grp_q       <= '0;
      ds_q        <= '0;
      w_q         <= '0;
      err_q       <= '0;
      rate_q      <= '0;
      decay_q     <= '0;
      bc_q        <= '0;
      wn_q        <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else if (bus.bp_flush) begin
      // Partial results are deliberately left in place.
      state_q     <= StIdle;
      grp_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.bp_in_valid) begin
            ds_q    <= bus.bp_ds;
            w_q     <= bus.bp_w;
            err_q   <= bus.bp_err;
            rate_q  <= bus.bp_rate;
            decay_q <= bus.bp_decay;
            grp_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          for (int l = 0; l < LANES; l++) begin
            if (l_en[l]) begin
              wn_q[WW'(l_idx[l])] <= l_wn[l];
              bc_q[DW'(l_idx[l])] <= l_bc[l];
            end
          end
          if (grp_q == GW'(NG - 1)) begin
            grp_q   <= '0;
            state_q <= StThresh;
          end else begin
            grp_q <= grp_q + 1'b1;
          end
        end
        StThresh: begin
          wn_q[N_IN]  <= l_wn[0];
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.bp_out_ready) begin
            out_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 16'd1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bp_in_ready  = (state_q == StIdle) && !bus.bp_flush;
  assign bus.bp_out_valid = out_valid_q;
  assign bus.bp_bc        = bc_q;
  assign bus.bp_wn        = wn_q;
  assign bus.bp_busy      = (state_q != StIdle);
  assign bus.bp_upd_cnt   = cnt_q;

endmodule

// File: tb/tb_bp_seq_updater.sv
// Scoreboard bench: random and directed bundles checked against a plain-arithmetic model.
module tb_bp_seq_updater;

  localparam int unsigned N    = 32;
  localparam int unsigned L    = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned FRAC = 16;
  localparam int unsigned N6   = 6;
  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -MAXL - 64'sd1;

  typedef struct {
    logic [N-1:0][31:0] bc;
    logic [N:0][31:0]   wn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_seq_updater_if #(.N_IN(N), .W(W)) bus ();
  bp_seq_updater_if #(.N_IN(N6), .W(W)) bus6 ();

  bp_seq_updater #(.N_IN(N), .LANES(L), .W(W), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bp_seq_updater #(.N_IN(N6), .LANES(L), .W(W), .FRAC(FRAC)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [N-1:0][31:0] st_ds;
  logic [N:0][31:0]   st_w;
  logic [31:0]        st_err, st_rate, st_decay;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp_v);
    end
  endtask

  function automatic longint trunc_w(input longint x);
    int t;
    t = int'(x);
    return longint'(t);
  endfunction

  function automatic longint sat_w(input longint x);
    if (x > MAXL) return MAXL;
    if (x < MINL) return MINL;
    return x;
  endfunction

  // Reference model straight from the fixed-point update rules.
  function automatic exp_t model();
    exp_t   e;
    longint err, rate, decay, wi, di, grad, step, dec;
    err   = longint'($signed(st_err));
    rate  = longint'($signed(st_rate));
    decay = longint'($signed(st_decay));
    for (int i = 0; i < N; i++) begin
      wi   = longint'($signed(st_w[i]));
      di   = longint'($signed(st_ds[i]));
      grad = trunc_w((err * di) >>> FRAC);
      step = trunc_w((grad * rate) >>> FRAC);
      dec  = trunc_w((wi * decay) >>> FRAC);
      e.wn[i] = 32'(sat_w(wi + step - dec));
      e.bc[i] = 32'(sat_w((err * wi) >>> FRAC));
    end
    wi = longint'($signed(st_w[N]));
    e.wn[N] = 32'(sat_w(wi - trunc_w((err * rate) >>> FRAC) - trunc_w((wi * decay) >>> FRAC)));
    return e;
  endfunction

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.bp_out_valid && bus.bp_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty act=handshake exp=no_result");
      end else begin
        int bad_w, bad_b;
        mon_e = exp_q.pop_front();
        bad_w = -1;
        bad_b = -1;
        for (int i = 0; i <= N; i++) if (bad_w < 0 && bus.bp_wn[i] !== mon_e.wn[i]) bad_w = i;
        for (int i = 0; i < N; i++) if (bad_b < 0 && bus.bp_bc[i] !== mon_e.bc[i]) bad_b = i;
        checks++;
        if (bad_w >= 0) begin
          failures++;
          $display("FAIL wn[%0d] act=%h exp=%h", bad_w, bus.bp_wn[bad_w], mon_e.wn[bad_w]);
        end
        checks++;
        if (bad_b >= 0) begin
          failures++;
          $display("FAIL bc[%0d] act=%h exp=%h", bad_b, bus.bp_bc[bad_b], mon_e.bc[bad_b]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) bus.bp_ds[i] = $urandom;
    for (int i = 0; i <= N; i++) bus.bp_w[i] = $urandom;
    bus.bp_err   = $urandom;
    bus.bp_rate  = $urandom;
    bus.bp_decay = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.bp_in_ready && n < 100) begin
      tick();
      n++;
    end
    check("wait_idle", {63'd0, bus.bp_in_ready}, 64'd1);
  endtask

  task automatic accept();
    wait_idle();
    bus.bp_ds       = st_ds;
    bus.bp_w        = st_w;
    bus.bp_err      = st_err;
    bus.bp_rate     = st_rate;
    bus.bp_decay    = st_decay;
    bus.bp_in_valid = 1'b1;
    tick();
    exp_q.push_back(model());
    bus.bp_in_valid = 1'b0;
    scramble();
  endtask

  task automatic send_bundle(input int bp_cycles);
    int lat;
    logic [N:0][31:0]   snap_wn;
    logic [N-1:0][31:0] snap_bc;
    logic [15:0]        snap_cnt;
    bus.bp_out_ready = (bp_cycles == 0);
    accept();
    lat = 1;
    tick();
    while (!bus.bp_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd9);
    if (bp_cycles > 0) begin
      snap_wn  = bus.bp_wn;
      snap_bc  = bus.bp_bc;
      snap_cnt = bus.bp_upd_cnt;
      repeat (bp_cycles) begin
        tick();
        check("bp_valid", {63'd0, bus.bp_out_valid}, 64'd1);
        check("bp_in_ready", {63'd0, bus.bp_in_ready}, 64'd0);
        check("bp_cnt", {48'd0, bus.bp_upd_cnt}, {48'd0, snap_cnt});
        check("bp_stable", {63'd0, (bus.bp_wn == snap_wn) && (bus.bp_bc == snap_bc)}, 64'd1);
      end
      bus.bp_out_ready = 1'b1;
    end
    tick();
    exp_cnt++;
    check("post_valid", {63'd0, bus.bp_out_valid}, 64'd0);
    check("upd_cnt", {48'd0, bus.bp_upd_cnt}, 64'(exp_cnt % 65536));
  endtask

  task automatic fill(input logic [31:0] ds, input logic [31:0] w, input logic [31:0] err,
                      input logic [31:0] rate, input logic [31:0] decay);
    for (int i = 0; i < N; i++) st_ds[i] = ds;
    for (int i = 0; i <= N; i++) st_w[i] = w;
    st_err   = err;
    st_rate  = rate;
    st_decay = decay;
  endtask

  task automatic fill_random();
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < N; i++) st_ds[i] = (mode == 0) ? $urandom : 32'($signed($urandom_range(0, 32'h3_FFFF)) - 32'sh2_0000);
    for (int i = 0; i <= N; i++) st_w[i] = (mode == 2) ? $urandom : 32'($signed($urandom_range(0, 32'h7F_FFFF)) - 32'sh40_0000);
    st_err   = (mode == 0) ? $urandom : 32'($signed($urandom_range(0, 32'h3_FFFF)) - 32'sh2_0000);
    st_rate  = $urandom_range(0, 32'h1_0000);
    st_decay = $urandom_range(0, 32'h1000);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    bus.bp_in_valid  = 1'b0;
    bus.bp_flush     = 1'b0;
    bus.bp_out_ready = 1'b1;
    bus6.bp_in_valid  = 1'b0;
    bus6.bp_flush     = 1'b0;
    bus6.bp_out_ready = 1'b1;
    bus6.bp_ds = '0;
    bus6.bp_w  = '0;
    bus6.bp_err   = '0;
    bus6.bp_rate  = '0;
    bus6.bp_decay = '0;
    scramble();
    #1;
    check("rst_out_valid", {63'd0, bus.bp_out_valid}, 64'd0);
    check("rst_wn0", {32'd0, bus.bp_wn[0]}, 64'd0);
    check("rst_bc0", {32'd0, bus.bp_bc[0]}, 64'd0);
    check("rst_cnt", {48'd0, bus.bp_upd_cnt}, 64'd0);
    check("rst_busy", {63'd0, bus.bp_busy}, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_ready", {63'd0, bus.bp_in_ready}, 64'd1);

    // Nominal, saturation and decay cases.
    fill(32'h0000_8000, 32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0);
    send_bundle(0);
    fill(32'h0001_0000, 32'h7FFF_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
    send_bundle(0);
    fill(32'hFFFF_0000, 32'h8000_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
    send_bundle(0);
    fill(32'h0, 32'h0002_0000, 32'h0, 32'h0, 32'h0000_8000);
    st_w[N] = 32'h0006_0000;
    send_bundle(0);
    fill(32'h0000_8000, 32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0);
    send_bundle(5);

    for (int k = 0; k < 8; k++) begin
      fill_random();
      send_bundle($urandom_range(0, 3));
    end

    // Flush in IDLE blocks acceptance.
    bus.bp_flush    = 1'b1;
    bus.bp_in_valid = 1'b1;
    #1;
    check("flush_idle_ready", {63'd0, bus.bp_in_ready}, 64'd0);
    tick();
    check("flush_idle_busy", {63'd0, bus.bp_busy}, 64'd0);
    bus.bp_flush    = 1'b0;
    bus.bp_in_valid = 1'b0;

    // Flush in the first RUN cycle.
    fill_random();
    bus.bp_out_ready = 1'b1;
    accept();
    bus.bp_flush = 1'b1;
    tick();
    bus.bp_flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_busy", {63'd0, bus.bp_busy}, 64'd0);
    check("flush_valid", {63'd0, bus.bp_out_valid}, 64'd0);
    check("flush_cnt", {48'd0, bus.bp_upd_cnt}, 64'(exp_cnt % 65536));
    repeat (12) tick();
    check("flush_no_valid", {63'd0, bus.bp_out_valid}, 64'd0);

    // Non-multiple depth on the 6-input instance.
    for (int i = 0; i < N6; i++) begin
      bus6.bp_ds[i] = 32'h0000_8000;
      bus6.bp_w[i]  = 32'h0;
    end
    bus6.bp_w[N6]     = 32'h0;
    bus6.bp_err       = 32'h0001_0000;
    bus6.bp_rate      = 32'h0000_8000;
    bus6.bp_decay     = 32'h0;
    bus6.bp_in_valid  = 1'b1;
    tick();
    bus6.bp_in_valid = 1'b0;
    bus6.bp_err      = 32'h1234_5678;
    lat = 1;
    tick();
    while (!bus6.bp_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("n6_latency", 64'(lat), 64'd3);
    for (int i = 0; i < N6; i++) begin
      check("n6_wn", {32'd0, bus6.bp_wn[i]}, 64'h4000);
      check("n6_bc", {32'd0, bus6.bp_bc[i]}, 64'd0);
    end
    check("n6_thresh", {32'd0, bus6.bp_wn[N6]}, 64'hFFFF_8000);
    tick();
    check("n6_cnt", {48'd0, bus6.bp_upd_cnt}, 64'd1);

    // Asynchronous reset in the middle of RUN.
    fill_random();
    accept();
    tick();
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    exp_cnt = 0;
    check("arst_busy", {63'd0, bus.bp_busy}, 64'd0);
    check("arst_valid", {63'd0, bus.bp_out_valid}, 64'd0);
    check("arst_wn", {63'd0, bus.bp_wn == '0}, 64'd1);
    check("arst_bc", {63'd0, bus.bp_bc == '0}, 64'd1);
    check("arst_cnt", {48'd0, bus.bp_upd_cnt}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fill(32'h0000_8000, 32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0);
    send_bundle(0);
    repeat (2) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
